// File: rtl/store_buffer_if.sv
// Bus bundles for the store buffer: pipeline-side store/load/status port and
// the data-memory drain port.
interface store_buffer_if #(parameter int PTR_W = 2);
  logic         st_valid;
  logic [3:0]   st_we;
  logic [31:0]  st_addr;
  logic [31:0]  st_wdata;
  logic         st_ready;
  logic         ld_valid;
  logic [31:0]  ld_addr;
  logic         ld_hazard;
  logic         empty;
  logic [PTR_W:0] count;
  logic         misalign;

  modport master (
    output st_valid, st_we, st_addr, st_wdata, ld_valid, ld_addr,
    input  st_ready, ld_hazard, empty, count, misalign
  );
  modport slave (
    input  st_valid, st_we, st_addr, st_wdata, ld_valid, ld_addr,
    output st_ready, ld_hazard, empty, count, misalign
  );
endinterface

interface store_buffer_mem_if;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [3:0]   mem_we;
  logic [31:0]  mem_wdata;
  logic         mem_ack;

  modport master (output mem_req, mem_addr, mem_we, mem_wdata, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_we, mem_wdata, output mem_ack);
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: lane-aligns stores, queues them, drains over req/ack
// and flags load hazards. STORE_BUF_MISALIGN_TRAP_EN drops misaligned stores.

// Per-entry word-address comparator for the load hazard check.
module store_buffer_hit (
  input  logic        vld,
  input  logic [29:0] ent_word,
  input  logic [29:0] ld_word,
  output logic        hit
);
  assign hit = vld & (ent_word == ld_word);
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  store_buffer_if.slave       st,
  store_buffer_mem_if.master  mem
);
  typedef struct packed {
    logic [29:0] word;
    logic [3:0]  we;
    logic [31:0] wdata;
  } sb_entry_t;

  sb_entry_t            ent_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count_q;
  logic [DEPTH-1:0]     ent_vld, hit;

  logic [1:0]           o;
  logic [7:0]           we_sh;
  logic [31:0]          wdata_sh;
  logic                 is_store, mis, push, pop;
  sb_entry_t            new_ent;

  assign o        = st.st_addr[1:0];
  assign we_sh    = {4'b0000, st.st_we} << o;
  assign wdata_sh = st.st_wdata << {o, 3'b000};
  assign new_ent  = '{word: st.st_addr[31:2], we: we_sh[3:0], wdata: wdata_sh};

  assign st.st_ready = count_q < (PTR_W+1)'(DEPTH);
  assign is_store    = st.st_valid & (st.st_we != 4'b0000) & st.st_ready;

`ifdef STORE_BUF_MISALIGN_TRAP_EN
  logic misalign_q;
  assign mis = ((st.st_we == 4'b0011) && (o == 2'd3)) ||
               ((st.st_we == 4'b1111) && (o != 2'd0));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= is_store & mis;
  end
  assign st.misalign = misalign_q;
`else
  // Misaligned stores go through with upper lanes shifted out.
  assign mis         = 1'b0;
  assign st.misalign = 1'b0;
`endif

  assign push = is_store & ~mis;
  assign pop  = mem.mem_req & mem.mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload needs no reset; occupancy comes from pointers and count.
  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr] <= new_ent;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off        = PTR_W'(i) - rd_ptr;
    assign ent_vld[i] = {1'b0, off} < count_q;
    store_buffer_hit u_hit (
      .vld      (ent_vld[i]),
      .ent_word (ent_q[i].word),
      .ld_word  (st.ld_addr[31:2]),
      .hit      (hit[i])
    );
  end

  logic unused_ld_lo;
  assign unused_ld_lo = ^st.ld_addr[1:0];

  assign st.ld_hazard = st.ld_valid & (|hit);
  assign st.empty     = (count_q == '0);
  assign st.count     = count_q;

  assign mem.mem_req   = ~st.empty;
  assign mem.mem_addr  = {ent_q[rd_ptr].word, 2'b00};
  assign mem.mem_we    = ent_q[rd_ptr].we;
  assign mem.mem_wdata = ent_q[rd_ptr].wdata;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; expectations are hand-computed constants.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;

  store_buffer_if #(.PTR_W(2)) st ();
  store_buffer_mem_if          mem ();

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .st  (st.slave),
    .mem (mem.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h want %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] d);
    st.st_valid = v;
    st.st_we    = we;
    st.st_addr  = a;
    st.st_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    st.ld_valid = 1'b1;
    st.ld_addr  = 32'h0;
    mem.mem_ack = 1'b0;
    step(); step();
    check("rst_count",    32'(st.count),    32'd0);
    check("rst_empty",    32'(st.empty),    32'd1);
    check("rst_req",      32'(mem.mem_req), 32'd0);
    check("rst_ready",    32'(st.st_ready), 32'd1);
    check("rst_misalign", 32'(st.misalign), 32'd0);
    check("rst_hazard",   32'(st.ld_hazard), 32'd0);
    rst = 1'b0;
    st.ld_valid = 1'b0;
    step();

    // SB to 0x103 lands in lane 3
    drive_st(1'b1, 4'b0001, 32'h103, 32'h0000_00AB);
    step();
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("sb_req",   32'(mem.mem_req), 32'd1);
    check("sb_addr",  mem.mem_addr,     32'h100);
    check("sb_we",    32'(mem.mem_we),  32'h8);
    check("sb_wdata", mem.mem_wdata,    32'hAB00_0000);
    check("sb_count", 32'(st.count),    32'd1);
    step(); step();
    check("sb_hold_addr",  mem.mem_addr,    32'h100);
    check("sb_hold_wdata", mem.mem_wdata,   32'hAB00_0000);
    check("sb_hold_we",    32'(mem.mem_we), 32'h8);
    mem.mem_ack = 1'b1;
    step();
    mem.mem_ack = 1'b0;
    #1;
    check("sb_drained_empty", 32'(st.empty),    32'd1);
    check("sb_drained_req",   32'(mem.mem_req), 32'd0);

    // Fill, refuse a 5th, drain in order (pointers wrap)
    for (int i = 0; i < 4; i++) begin
      drive_st(1'b1, 4'hF, 32'(i * 4), 32'h1000 + 32'(i));
      step();
    end
    drive_st(1'b1, 4'hF, 32'h10, 32'hDEAD);
    #1;
    check("full_count", 32'(st.count),    32'd4);
    check("full_ready", 32'(st.st_ready), 32'd0);
    step();
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("full_5th_refused", 32'(st.count), 32'd4);
    mem.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("order_addr%0d", i),  mem.mem_addr,  32'(i * 4));
      check($sformatf("order_wdata%0d", i), mem.mem_wdata, 32'h1000 + 32'(i));
      step();
    end
    mem.mem_ack = 1'b0;
    #1;
    check("order_empty", 32'(st.empty), 32'd1);

    // Full with pop and store in the same cycle: store refused, then accepted
    for (int i = 0; i < 4; i++) begin
      drive_st(1'b1, 4'hF, 32'h40 + 32'(i * 4), 32'h0);
      step();
    end
    drive_st(1'b1, 4'hF, 32'h50, 32'h55);
    mem.mem_ack = 1'b1;
    #1;
    check("popfull_ready", 32'(st.st_ready), 32'd0);
    step();
    mem.mem_ack = 1'b0;
    #1;
    check("popfull_count", 32'(st.count),    32'd3);
    check("popfull_ready2", 32'(st.st_ready), 32'd1);
    step();
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("popfull_accepted", 32'(st.count), 32'd4);
    mem.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("popfull_addr%0d", i), mem.mem_addr, 32'h44 + 32'(i * 4));
      step();
    end
    mem.mem_ack = 1'b0;
    #1;
    check("popfull_empty", 32'(st.empty), 32'd1);

    // Load hazard
    drive_st(1'b1, 4'b0011, 32'h202, 32'h0000_BEEF);
    step();
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    st.ld_valid = 1'b1;
    st.ld_addr  = 32'h200;
    #1;
    check("sh_we",      32'(mem.mem_we),   32'hC);
    check("sh_wdata",   mem.mem_wdata,     32'hBEEF_0000);
    check("haz_hit",    32'(st.ld_hazard), 32'd1);
    st.ld_addr = 32'h204;
    #1;
    check("haz_miss",   32'(st.ld_hazard), 32'd0);
    st.ld_addr  = 32'h203;
    mem.mem_ack = 1'b1;
    #1;
    check("haz_popping", 32'(st.ld_hazard), 32'd1);
    step();
    mem.mem_ack = 1'b0;
    #1;
    check("haz_drained", 32'(st.ld_hazard), 32'd0);
    drive_st(1'b1, 4'hF, 32'h200, 32'h1);
    #1;
    check("haz_enq_same_cycle", 32'(st.ld_hazard), 32'd0);
    step();
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("haz_enq_next_cycle", 32'(st.ld_hazard), 32'd1);
    mem.mem_ack = 1'b1;
    step();
    mem.mem_ack = 1'b0;
    st.ld_valid = 1'b0;
    #1;
    check("haz_ldvalid_low", 32'(st.ld_hazard), 32'd0);

    // Non-store op
    drive_st(1'b1, 4'h0, 32'h300, 32'hFFFF);
    step();
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("alu_count", 32'(st.count),    32'd0);
    check("alu_req",   32'(mem.mem_req), 32'd0);

    // Misaligned SW at 0x302
    drive_st(1'b1, 4'hF, 32'h302, 32'h1122_3344);
    step();
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
`ifdef STORE_BUF_MISALIGN_TRAP_EN
    check("mis_pulse", 32'(st.misalign), 32'd1);
    check("mis_count", 32'(st.count),    32'd0);
    step();
    check("mis_pulse_end", 32'(st.misalign), 32'd0);
`else
    check("mis_off_flag",  32'(st.misalign), 32'd0);
    check("mis_off_count", 32'(st.count),    32'd1);
    check("mis_off_we",    32'(mem.mem_we),  32'hC);
    check("mis_off_wdata", mem.mem_wdata,    32'h3344_0000);
    mem.mem_ack = 1'b1;
    step();
    mem.mem_ack = 1'b0;
`endif

    // Async reset with pending entries
    for (int i = 0; i < 2; i++) begin
      drive_st(1'b1, 4'hF, 32'h400 + 32'(i * 4), 32'h0);
      step();
    end
    drive_st(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("pre_rst_count", 32'(st.count), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(st.count),    32'd0);
    check("async_rst_req",   32'(mem.mem_req), 32'd0);
    check("async_rst_empty", 32'(st.empty),    32'd1);
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the store write-enable generator and data memory.
- Accepts stores carrying a low-aligned byte mask (0001 SB, 0011 SH, 1111 SW) plus address and data, and aligns mask and data to the byte lane given by addr[1:0].
- Queues aligned stores in an in-order FIFO and drains them to data memory over a req/ack handshake.
- Flags loads that hit a pending store word so the pipeline stalls until that store drains.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- st_valid  in  1  store presented this cycle.
- st_we  in  4  low-aligned byte mask from write-enable generator.
- st_addr  in  32  byte address of store.
- st_wdata  in  32  store data, LSB-aligned.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  load in memory stage.
- ld_addr  in  32  load byte address.
- ld_hazard  out  1  load word matches a pending store; stall.
- mem_req  out  1  head entry valid, write requested.
- mem_addr  out  32  word-aligned address, low 2 bits = 0.
- mem_we  out  4  aligned byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_ack  in  1  memory accepted head this cycle.
- empty  out  1  no pending stores.
- count  out  PTR_W+1  number of pending entries.
- misalign  out  1  misaligned store dropped; tied 0 unless feature enabled.

Behaviour:
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, count=0, empty=1, mem_req=0, st_ready=1, misalign=0, ld_hazard=0. All pending stores are discarded, including any mid-handshake head; entry contents are don't-care.
- Alignment at enqueue, with o = st_addr[1:0]:
  - entry.we = (st_we << o)[3:0]
  - entry.wdata = (st_wdata << 8*o)[31:0]
  - entry.addr = {st_addr[31:2], 2'b00}
- Enqueue occurs on the rising edge when st_valid=1, st_we≠0, st_ready=1 (and not misaligned when the feature is on).
- st_valid with st_we=0 (non-store op) is ignored and causes no state change.
- st_ready = (count < DEPTH); it depends only on registered state.
- Full: st_ready=0 even if a pop happens the same cycle. A store presented while full is not captured, and the upstream must hold it.
- Drain:
  - mem_req = !empty; mem_addr/mem_we/mem_wdata are driven from the head entry and held stable while mem_req=1 and mem_ack=0.
  - Pop occurs on the edge with mem_req=1 and mem_ack=1.
  - mem_ack while empty is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a store enqueued at edge N appears on mem_req in the cycle after N at the earliest; throughput is 1 store/cycle in and out.
- Ordering: strict FIFO; memory sees stores in acceptance order.
- ld_hazard (combinational) = ld_valid AND any valid entry whose addr[31:2] equals ld_addr[31:2].
  - The entry being popped this cycle still counts.
  - A store being enqueued this cycle does not count.
- empty = (count==0).

Optional Feature:
- Macro: STORE_BUF_MISALIGN_TRAP_EN.
- Defined — a store is misaligned when st_we=0011 with o=3, or st_we=1111 with o≠0. A misaligned store:
  - is not enqueued;
  - pulses misalign=1 for exactly one cycle, registered and asserted in the cycle after the offending accepted-handshake edge;
  - still sees st_ready honoured, so the pulse is generated only when st_ready=1.
- Not defined — misaligned stores are enqueued with the shifted mask and data truncated to 4 bits / 32 bits (upper lanes dropped), and misalign is constant 0.

Test Plan:
- Reset then SB st_we=0001, addr=0x103, data=0x000000AB; hold mem_ack=0 -> next cycle mem_req=1, mem_addr=0x100, mem_we=1000, mem_wdata=0xAB000000, count=1; these values stay stable until mem_ack=1, then empty=1.
- Push 4 SW stores to 0x0,0x4,0x8,0xC with mem_ack=0 -> st_ready=0 with count=4; a 5th store is not captured. Then hold mem_ack=1 for 4 cycles -> memory sees the addresses in order 0x0,0x4,0x8,0xC.
- Full buffer with mem_ack=1 and st_valid=1 in the same cycle -> the store is refused (st_ready=0) and count drops to 3; the next cycle it is accepted.
- Pending SH at 0x202, ld_valid=1 with ld_addr=0x200 -> ld_hazard=1; with ld_addr=0x204 -> ld_hazard=0; after the entry drains -> ld_hazard=0.
- st_valid=1 with st_we=0000 (ALU op) -> count unchanged, mem_req stays 0.
- Feature on: SW at 0x302 -> misalign=1 for one cycle, count stays 0. Feature off: the same store enqueues with mem_we=1100 and mem_wdata=data<<16. Also assert rst while count=2 -> count=0 and mem_req=0 immediately.
